// File: rtl/eq_vector_sequencer_pkg.sv
// Shared definitions for the equality-comparator vector sequencer: widths, state
// encodings, vector field offsets and the n_vec clamp helper.
package eq_vector_sequencer_pkg;

    localparam int unsigned DATA_W = 2;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned VEC_W  = 2 * DATA_W + 1;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    // Vector layout is {a, b, expected}
    localparam int unsigned EXP_BIT = 0;
    localparam int unsigned B_LSB   = 1;
    localparam int unsigned A_LSB   = 1 + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] clamp_n(input logic [CNT_W-1:0] n);
        return (n > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : n;
    endfunction

endpackage

// File: rtl/eq_vector_sequencer_eq_n.sv
// DATA_W-wide equality comparator; the resource exercised by the sequencer.
module eq_n
    import eq_vector_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              aeqb
);

    assign aeqb = (a == b);

endmodule

// File: rtl/eq_vector_sequencer.sv
// Runs a loadable table of {a,b,expected} vectors through eq_n and tallies pass/fail.
// Define EQ_SEQ_STOP_ON_FAIL_EN to end the run at the first mismatching vector.
module eq_vector_sequencer
    import eq_vector_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [VEC_W-1:0]  wr_data,
    input  logic [CNT_W-1:0]  n_vec,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [ADDR_W-1:0] first_fail
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [CNT_W-1:0]    pass_q, pass_d;
    logic [CNT_W-1:0]    fail_q, fail_d;
    logic [ADDR_W-1:0]   ff_q, ff_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aeqb_q, aeqb_d;
    logic                exp_q, exp_d;

    logic [VEC_W-1:0]    tbl_q [DEPTH];
    logic [VEC_W-1:0]    rd_vec;
    logic                cmp_eq;
    logic [CNT_W-1:0]    n_clamped;
    logic                mismatch;

    // Table is not reset; writes only land while the sequencer is idle
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == ST_IDLE)) begin
            tbl_q[wr_addr] <= wr_data;
        end
    end

    assign rd_vec    = tbl_q[idx_q[ADDR_W-1:0]];
    assign n_clamped = clamp_n(n_vec);
    assign mismatch  = (aeqb_q != exp_q);

    eq_n u_eq (
        .a    (rd_vec[A_LSB +: DATA_W]),
        .b    (rd_vec[B_LSB +: DATA_W]),
        .aeqb (cmp_eq)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        ff_d    = ff_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        aeqb_d  = aeqb_q;
        exp_d   = exp_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d     = n_clamped;
                    idx_d   = '0;
                    pass_d  = '0;
                    fail_d  = '0;
                    ff_d    = '0;
                    busy_d  = 1'b1;
                    state_d = (n_clamped == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                aeqb_d  = cmp_eq;
                exp_d   = rd_vec[EXP_BIT];
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                idx_d = idx_q + CNT_W'(1);
                if (mismatch) begin
                    fail_d = fail_q + CNT_W'(1);
                    if (fail_q == '0) begin
                        ff_d = idx_q[ADDR_W-1:0];
                    end
                end else begin
                    pass_d = pass_q + CNT_W'(1);
                end
                state_d = (idx_d == n_q) ? ST_DONE : ST_FETCH;
`ifdef EQ_SEQ_STOP_ON_FAIL_EN
                if (mismatch) begin
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            ff_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            aeqb_q  <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ff_q    <= ff_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            aeqb_q  <= aeqb_d;
            exp_q   <= exp_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass_cnt   = pass_q;
    assign fail_cnt   = fail_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_eq_vector_sequencer.sv
// Directed self-checking bench for eq_vector_sequencer; expectations follow the
// EQ_SEQ_STOP_ON_FAIL_EN setting of the build.
module tb_eq_vector_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic [3:0] n_vec;
    logic       busy;
    logic       done;
    logic [3:0] pass_cnt;
    logic [3:0] fail_cnt;
    logic [2:0] first_fail;

    int checks = 0;
    int errors = 0;

`ifdef EQ_SEQ_STOP_ON_FAIL_EN
    localparam int C_PASS = 5;
    localparam int C_LAT  = 13;
`else
    localparam int C_PASS = 7;
    localparam int C_LAT  = 17;
`endif

    always #5 clk = ~clk;

    eq_vector_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .n_vec      (n_vec),
        .busy       (busy),
        .done       (done),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .first_fail (first_fail)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic write_vec(input logic [2:0] addr, input logic [4:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Start a run; optionally write in the start cycle, optionally poke start+wr_en mid-run.
    task automatic run(input string tag, input logic [3:0] n, input bit pre_wr,
                       input logic [4:0] pre_data, input int poke, output int lat);
        @(negedge clk);
        n_vec = n;
        start = 1'b1;
        if (pre_wr) begin
            wr_en   = 1'b1;
            wr_addr = 3'd0;
            wr_data = pre_data;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        chk({tag, "_busy_early"}, 32'(busy), 32'd1);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            wr_en = 1'b0;
            if (c == poke) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = 3'd0;
                wr_data = 5'b11001;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (lat > 0) begin
            chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            chk({tag, "_done_width"}, 32'(done), 32'd0);
        end
    endtask

    task automatic run_chk(input string tag, input logic [3:0] n, input bit pre_wr,
                           input logic [4:0] pre_data, input int poke,
                           input int e_lat, input int e_pass, input int e_fail, input int e_ff);
        int lat;
        run(tag, n, pre_wr, pre_data, poke, lat);
        chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
        chk({tag, "_pass"}, 32'(pass_cnt), 32'(e_pass));
        chk({tag, "_fail"}, 32'(fail_cnt), 32'(e_fail));
        if (e_fail != 0) chk({tag, "_first_fail"}, 32'(first_fail), 32'(e_ff));
    endtask

    initial begin
        int dones;
        logic [4:0] vecs [8];
        vecs[0] = 5'b00001; vecs[1] = 5'b01011; vecs[2] = 5'b10110; vecs[3] = 5'b11111;
        vecs[4] = 5'b00010; vecs[5] = 5'b10101; vecs[6] = 5'b01100; vecs[7] = 5'b11000;

        reset = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; n_vec = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass_cnt), 32'd0);
        chk("rst_fail", 32'(fail_cnt), 32'd0);
        chk("rst_ff", 32'(first_fail), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) write_vec(3'(i), vecs[i]);
        run_chk("t1_all_pass", 4'd8, 1'b0, 5'd0, 0, 17, 8, 0, 0);

        write_vec(3'd5, 5'b10100);
        run_chk("t2_corrupt", 4'd8, 1'b0, 5'd0, 0, C_LAT, C_PASS, 1, 5);

        run_chk("t3_zero", 4'd0, 1'b0, 5'd0, 0, 1, 0, 0, 0);
        run_chk("t3_clamp", 4'd12, 1'b0, 5'd0, 0, C_LAT, C_PASS, 1, 5);

        run_chk("t4_poke", 4'd8, 1'b0, 5'd0, 3, C_LAT, C_PASS, 1, 5);
        run_chk("t4_after", 4'd8, 1'b0, 5'd0, 0, C_LAT, C_PASS, 1, 5);

        // Reset lands on the edge that would end the third CHECK
        @(negedge clk);
        n_vec = 4'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_pre_pass", 32'(pass_cnt), 32'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_pass", 32'(pass_cnt), 32'd0);
        chk("t5_fail", 32'(fail_cnt), 32'd0);
        chk("t5_ff", 32'(first_fail), 32'd0);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk("t5_no_done", 32'(dones), 32'd0);
        run_chk("t5_rerun", 4'd8, 1'b0, 5'd0, 0, C_LAT, C_PASS, 1, 5);

        run_chk("t6_wr_start", 4'd1, 1'b1, 5'b01101, 0, 3, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
